// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the serial frame width, the default bit period and the byte-FSM state encoding
// used by uart_byte_rx.
package uart_pkg;

  // Data bits per UART character (8N1 framing).
  localparam int unsigned UART_DATA_BITS = 8;

  // 100 MHz system clock at 115200 baud.
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

  // Byte-FSM state type and encodings.
  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_START = 3'd1;
  localparam rx_state_t ST_DATA  = 3'd2;
  localparam rx_state_t ST_STOP  = 3'd3;
  localparam rx_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-FF synchroniser on the serial line plus the 8N1 byte FSM.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_rx          raw UART serial input, idle high, LSB first
//   o_byte_valid  one-cycle pulse, o_byte_data holds a correctly framed byte
//   o_byte_data   received byte
//   o_frame_err   one-cycle pulse, stop bit sampled low (byte discarded)
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx,
  output logic                      o_byte_valid,
  output logic [UART_DATA_BITS-1:0] o_byte_data,
  output logic                      o_frame_err
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      r_rx_meta;
  logic                      r_rx_s;
  logic                      r_rx_d;
  logic [2:0]                r_arm;
  rx_state_t                 r_state;
  logic [TW-1:0]             r_timer;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_byte_valid;
  logic [UART_DATA_BITS-1:0] r_byte_data;
  logic                      r_frame_err;

  rx_state_t                 w_state_nxt;
  logic [TW-1:0]             w_timer_nxt;
  logic [2:0]                w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      w_byte_valid_nxt;
  logic [UART_DATA_BITS-1:0] w_byte_data_nxt;
  logic                      w_frame_err_nxt;
  logic                      w_fall;

  // A start bit is a high-to-low edge, not a low level. r_arm holds off edge detection until
  // r_rx_d carries a real line sample, so a line that is already low when reset is released
  // (mid-byte) is ignored until it returns high and falls again.
  assign w_fall = r_arm[2] & r_rx_d & ~r_rx_s;

  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_byte_valid_nxt = 1'b0;
    w_byte_data_nxt  = r_byte_data;
    w_frame_err_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_timer_nxt = '0;
        end
      end

      ST_START: begin
        if (r_timer == HALF_M1) begin
          w_timer_nxt   = '0;
          w_bit_idx_nxt = '0;
          // Line back high at mid start bit: treat as a glitch, no error.
          w_state_nxt   = r_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      ST_DATA: begin
        if (r_timer == FULL_M1) begin
          w_timer_nxt = '0;
          w_shift_nxt = {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      ST_STOP: begin
        if (r_timer == FULL_M1) begin
          w_timer_nxt = '0;
          if (r_rx_s) begin
            w_byte_valid_nxt = 1'b1;
            w_byte_data_nxt  = r_shift;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = ST_BREAK;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      ST_BREAK: begin
        // Stay here through a break / stuck-low line; resume once it is idle again.
        if (r_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_rx_d       <= 1'b1;
      r_arm        <= '0;
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= i_rx;
      r_rx_s       <= r_rx_meta;
      r_rx_d       <= r_rx_s;
      r_arm        <= {r_arm[1:0], 1'b1};
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_byte_data  <= w_byte_data_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_byte_data;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver for the PUF challenge path. Packs WORD_BYTES received bytes (first byte
// in the MSB position) into one word and offers it on a valid/ready handshake. Framing errors
// and inter-byte timeouts discard the partial word; a word completing while the previous one
// is still unconsumed is dropped and flagged.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_rx           UART serial input, idle high, 8N1, LSB first
//   o_word_data    assembled word
//   o_word_valid   o_word_data holds an unconsumed word
//   i_word_ready   consumer accepts when o_word_valid && i_word_ready at a rising edge
//   o_frame_err    one-cycle pulse: stop bit sampled low
//   o_timeout_err  one-cycle pulse: partial word discarded after rx silence
//   o_overrun_err  one-cycle pulse: completed word dropped, previous word unconsumed
//   o_byte_count   bytes held in the current partial word
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned WORD_BYTES   = 8,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_rx,
  output logic [UART_DATA_BITS*WORD_BYTES-1:0] o_word_data,
  output logic                                o_word_valid,
  input  logic                                i_word_ready,
  output logic                                o_frame_err,
  output logic                                o_timeout_err,
  output logic                                o_overrun_err,
  output logic [2:0]                          o_byte_count
);

  localparam int unsigned WORD_W   = UART_DATA_BITS * WORD_BYTES;
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LIMIT - 1);
  localparam logic [2:0]      LAST_BYTE = 3'(WORD_BYTES - 1);

  logic                      w_byte_valid;
  logic [UART_DATA_BITS-1:0] w_byte_data;
  logic                      w_frame_err;
  logic [WORD_W-1:0]         w_full_word;
  logic                      w_accept;

  logic [WORD_W-1:0]         r_sr;
  logic [2:0]                r_byte_count;
  logic [TO_W-1:0]           r_to_cnt;
  logic [WORD_W-1:0]         r_word_data;
  logic                      r_word_valid;
  logic                      r_timeout_err;
  logic                      r_overrun_err;

  logic [WORD_W-1:0]         w_sr_nxt;
  logic [2:0]                w_byte_count_nxt;
  logic [TO_W-1:0]           w_to_cnt_nxt;
  logic [WORD_W-1:0]         w_word_data_nxt;
  logic                      w_word_valid_nxt;
  logic                      w_timeout_err_nxt;
  logic                      w_overrun_err_nxt;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx         (i_rx),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_frame_err  (w_frame_err)
  );

  // Shift register contents with the incoming byte appended; this is the finished word when
  // the incoming byte is the last one, so it can be loaded straight into o_word_data.
  if (WORD_BYTES > 1) begin : g_multi
    assign w_full_word = {r_sr[WORD_W-UART_DATA_BITS-1:0], w_byte_data};
  end else begin : g_single
    assign w_full_word = w_byte_data;
  end

  assign w_accept = r_word_valid & i_word_ready;

  always_comb begin
    w_sr_nxt          = r_sr;
    w_byte_count_nxt  = r_byte_count;
    w_to_cnt_nxt      = r_to_cnt;
    w_word_data_nxt   = r_word_data;
    w_word_valid_nxt  = r_word_valid;
    w_timeout_err_nxt = 1'b0;
    w_overrun_err_nxt = 1'b0;

    if (w_accept) begin
      w_word_valid_nxt = 1'b0;
    end

    if (w_byte_valid) begin
      w_sr_nxt     = w_full_word;
      w_to_cnt_nxt = '0;
      if (r_byte_count == LAST_BYTE) begin
        w_byte_count_nxt = '0;
        // Output slot is free, or is being emptied on this very edge.
        if (!r_word_valid || i_word_ready) begin
          w_word_data_nxt  = w_full_word;
          w_word_valid_nxt = 1'b1;
        end else begin
          w_overrun_err_nxt = 1'b1;
        end
      end else begin
        w_byte_count_nxt = r_byte_count + 3'd1;
      end
    end else if (w_frame_err) begin
      // Resync: a bad frame invalidates whatever partial word was being built.
      w_byte_count_nxt = '0;
      w_to_cnt_nxt     = '0;
    end else if (r_byte_count != '0) begin
      if (r_to_cnt == TO_LAST) begin
        w_byte_count_nxt  = '0;
        w_to_cnt_nxt      = '0;
        w_timeout_err_nxt = 1'b1;
      end else begin
        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
      end
    end else begin
      w_to_cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr          <= '0;
      r_byte_count  <= '0;
      r_to_cnt      <= '0;
      r_word_data   <= '0;
      r_word_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_sr          <= w_sr_nxt;
      r_byte_count  <= w_byte_count_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_word_data   <= w_word_data_nxt;
      r_word_valid  <= w_word_valid_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_overrun_err <= w_overrun_err_nxt;
    end
  end

  assign o_word_data   = r_word_data;
  assign o_word_valid  = r_word_valid;
  assign o_frame_err   = w_frame_err;
  assign o_timeout_err = r_timeout_err;
  assign o_overrun_err = r_overrun_err;
  assign o_byte_count  = r_byte_count;

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx (CLKS_PER_BIT=16, WORD_BYTES=8, TIMEOUT_BITS=20).
// A transaction-level model tracks the partial word as a byte queue, the output slot as a
// held word plus valid flag, and counts of each error event.
module tb_uart_word_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned WB  = 8;
  localparam int unsigned TOB = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx = 1'b1;
  logic        word_ready = 1'b0;
  logic [63:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        timeout_err;
  logic        overrun_err;
  logic [2:0]  byte_count;

  always #5 clk = ~clk;

  uart_word_rx #(
    .CLKS_PER_BIT (CPB),
    .WORD_BYTES   (WB),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx          (rx),
    .o_word_data   (word_data),
    .o_word_valid  (word_valid),
    .i_word_ready  (word_ready),
    .o_frame_err   (frame_err),
    .o_timeout_err (timeout_err),
    .o_overrun_err (overrun_err),
    .o_byte_count  (byte_count)
  );

  // Output monitor: records handshakes and counts pulses.
  logic [63:0] got_q[$];
  int n_frame = 0, n_timeout = 0, n_overrun = 0, n_valid_cycles = 0;

  always @(posedge clk) begin
    if (word_valid && word_ready) got_q.push_back(word_data);
    if (frame_err) n_frame <= n_frame + 1;
    if (timeout_err) n_timeout <= n_timeout + 1;
    if (overrun_err) n_overrun <= n_overrun + 1;
    if (word_valid) n_valid_cycles <= n_valid_cycles + 1;
  end

  // Reference model.
  logic [7:0]  m_part[$];
  logic [63:0] m_acc[$];
  logic [63:0] m_held = '0;
  bit          m_valid = 1'b0;
  int          m_ovr = 0, m_frame = 0, m_timeout = 0;
  int          chk_idx = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_word_done(input logic [63:0] w, input bit rdy, input bit rdy_after);
    if (!m_valid || rdy) begin
      if (m_valid) m_acc.push_back(m_held);
      m_held  = w;
      m_valid = 1'b1;
    end else begin
      m_ovr++;
    end
    if (m_valid && rdy_after) begin
      m_acc.push_back(m_held);
      m_valid = 1'b0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good, input bit rdy,
                            input bit rdy_after);
    logic [63:0] w;
    if (!good) begin
      m_part.delete();
      m_frame++;
    end else begin
      m_part.push_back(b);
      if (m_part.size() == WB) begin
        w = '0;
        foreach (m_part[i]) w = (w << 8) | 64'(m_part[i]);
        m_part.delete();
        model_word_done(w, rdy, rdy_after);
      end
    end
  endtask

  task automatic model_long_idle();
    if (m_part.size() != 0) begin
      m_part.delete();
      m_timeout++;
    end
  endtask

  task automatic model_reset();
    m_part.delete();
    m_valid = 1'b0;
  endtask

  // Compare all observable state against the model.
  task automatic check_state(input string tag);
    check({tag, "/valid"}, 64'(word_valid), 64'(m_valid));
    if (m_valid) check({tag, "/data"}, word_data, m_held);
    check({tag, "/byte_count"}, 64'(byte_count), 64'(m_part.size()));
    check({tag, "/overruns"}, 64'(n_overrun), 64'(m_ovr));
    check({tag, "/frame_errs"}, 64'(n_frame), 64'(m_frame));
    check({tag, "/timeouts"}, 64'(n_timeout), 64'(m_timeout));
    check({tag, "/accepted"}, 64'(got_q.size()), 64'(m_acc.size()));
    for (int i = chk_idx; i < m_acc.size() && i < got_q.size(); i++) begin
      check({tag, "/acc_word"}, got_q[i], m_acc[i]);
    end
    chk_idx = m_acc.size();
  endtask

  // Stimulus: all tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit rdy,
                           input bit rdy_after);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    model_byte(b, good_stop, rdy, rdy_after);
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = WB - 1; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1, word_ready, word_ready);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic consume();
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    if (m_valid) begin
      m_acc.push_back(m_held);
      m_valid = 1'b0;
    end
    idle(2);
  endtask

  logic [63:0] wa, wb, wr;
  int          vc0;
  bit          found;

  initial begin
    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("reset/valid", 64'(word_valid), 64'd0);
    check("reset/data", word_data, 64'd0);
    check("reset/byte_count", 64'(byte_count), 64'd0);
    check("reset/errs", 64'({frame_err, timeout_err, overrun_err}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // 1: basic word with ready held high; valid is a single-cycle pulse.
    word_ready = 1'b1;
    vc0 = n_valid_cycles;
    send_word(64'h0102030405060708);
    idle(4);
    check_state("t1");
    check("t1/valid_cycles", 64'(n_valid_cycles - vc0), 64'd1);

    // 2: overrun while the first word is held.
    word_ready = 1'b0;
    wa = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    send_word(wa);
    idle(4);
    check_state("t2a");
    send_word(wb);
    idle(4);
    check_state("t2b");
    consume();
    check_state("t2c");

    // 3: partial word timeout, then recovery.
    word_ready = 1'b1;
    send_byte(8'hAA, 1'b1, 1'b1, 1'b1);
    send_byte(8'hBB, 1'b1, 1'b1, 1'b1);
    send_byte(8'hCC, 1'b1, 1'b1, 1'b1);
    idle(2);
    check_state("t3a");
    idle(400);
    model_long_idle();
    check_state("t3b");
    send_word(64'h0102030405060708);
    idle(4);
    check_state("t3c");

    // 4: framing error clears the partial word.
    send_byte(8'($urandom), 1'b1, 1'b1, 1'b1);
    send_byte(8'($urandom), 1'b1, 1'b1, 1'b1);
    send_byte(8'h55, 1'b0, 1'b1, 1'b1);
    idle(20);
    check_state("t4a");
    send_word(64'h0102030405060708);
    idle(4);
    check_state("t4b");

    // 5: short glitch is ignored; reset mid-word loses everything.
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(50);
    check_state("t5a");
    word_ready = 1'b0;
    wr = {$urandom, $urandom};
    send_word(wr);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1'b0, 1'b0);
    idle(2);
    check_state("t5b");
    rx = 1'b0;
    idle(4 * CPB);
    rst_n = 1'b0;
    #1;
    check("t5/rst_valid", 64'(word_valid), 64'd0);
    check("t5/rst_data", word_data, 64'd0);
    check("t5/rst_byte_count", 64'(byte_count), 64'd0);
    check("t5/rst_errs", 64'({frame_err, timeout_err, overrun_err}), 64'd0);
    model_reset();
    idle(5);
    rst_n = 1'b1;
    idle(20);
    rx = 1'b1;
    idle(200);
    check_state("t5c");
    word_ready = 1'b1;
    send_word(64'h0102030405060708);
    idle(4);
    check_state("t5d");

    // 6: new word completes on the same edge the held word is consumed.
    word_ready = 1'b0;
    wa = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    send_word(wa);
    for (int i = WB - 1; i >= 1; i--) send_byte(wb[8*i +: 8], 1'b1, 1'b0, 1'b0);
    found = 1'b0;
    fork
      send_byte(wb[7:0], 1'b1, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge clk);
          if (dut.w_byte_valid) begin
            found = 1'b1;
            word_ready = 1'b1;
            @(negedge clk);
            word_ready = 1'b0;
          end
        end
      end
    join
    check("t6/byte_seen", 64'(found), 64'd1);
    idle(4);
    check_state("t6a");
    consume();
    check_state("t6b");

    // Random words with random consumer behaviour.
    for (int k = 0; k < 3; k++) begin
      wr = {$urandom, $urandom};
      word_ready = 1'($urandom_range(0, 1));
      send_word(wr);
      idle(4);
      check_state("rand_a");
      consume();
      check_state("rand_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
